// File: rtl/ahb_rr_burst_arbiter.sv
// Burst-aware round-robin output-stage arbiter for one shared AHB slave port.
// Define ARB_FIXED_PRIORITY_EN to use fixed priority instead (lowest index wins).
module ahb_rr_burst_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic                 burst_active
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [2:0] BURST_INCR = 3'b001;

    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic [PORT_W-1:0] addr_q, addr_d;
    logic              no_port_q, no_port_d;
    logic              burst_active_q;
    logic              accepted;
    logic              hold;
    logic              win_found;
    logic [PORT_W-1:0] win_idx;

    function automatic logic [3:0] remaining_beats(input logic [2:0] burst);
        case (burst[2:1])
            2'b01:   remaining_beats = 4'd3;
            2'b10:   remaining_beats = 4'd7;
            2'b11:   remaining_beats = 4'd15;
            default: remaining_beats = 4'd0;
        endcase
    endfunction

`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_port[i]) begin
                win_found = 1'b1;
                win_idx   = PORT_W'(i);
            end
        end
    end
`else
    localparam logic [PORT_W+1:0] NP = (PORT_W+2)'(NUM_PORTS);

    logic [PORT_W-1:0] rr_last_q, rr_last_d;
    logic [PORT_W-1:0] cand_idx [NUM_PORTS];

    // cand_idx[k] is the port visited at offset k+1 after rr_last, wrapped explicitly.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
            logic [PORT_W+1:0] sum;
            assign sum          = {2'b00, rr_last_q} + (PORT_W+2)'(gi + 1);
            assign cand_idx[gi] = (sum >= NP) ? PORT_W'(sum - NP) : PORT_W'(sum);
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req_port[cand_idx[k]]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end
`endif

    always_comb begin
        accepted   = HSELM && HTRANSM[1];
        beat_cnt_d = beat_cnt_q;
        if (HTRANSM == HT_IDLE) begin
            beat_cnt_d = 4'd0;
        end else if (HTRANSM == HT_NONSEQ) begin
            beat_cnt_d = accepted ? remaining_beats(HBURSTM) : 4'd0;
        end else if (HTRANSM == HT_SEQ && accepted && beat_cnt_q != 4'd0) begin
            beat_cnt_d = beat_cnt_q - 4'd1;
        end

        hold = HMASTLOCKM || (beat_cnt_d != 4'd0) ||
               (HBURSTM == BURST_INCR && HSELM && (HTRANSM == HT_BUSY || HTRANSM == HT_SEQ));

        addr_d    = addr_q;
        no_port_d = no_port_q;
`ifndef ARB_FIXED_PRIORITY_EN
        rr_last_d = rr_last_q;
`endif
        if (hold) begin
            no_port_d = 1'b0;
        end else if (win_found) begin
            addr_d    = win_idx;
            no_port_d = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
            rr_last_d = win_idx;
`endif
        end else begin
            no_port_d = !HSELM;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            beat_cnt_q     <= 4'd0;
            addr_q         <= '0;
            no_port_q      <= 1'b1;
            burst_active_q <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
            rr_last_q      <= PORT_W'(NUM_PORTS - 1);
`endif
        end else if (HREADYM) begin
            beat_cnt_q     <= beat_cnt_d;
            addr_q         <= addr_d;
            no_port_q      <= no_port_d;
            burst_active_q <= (beat_cnt_d != 4'd0);
`ifndef ARB_FIXED_PRIORITY_EN
            rr_last_q      <= rr_last_d;
`endif
        end
    end

    assign addr_in_port = addr_q;
    assign no_port      = no_port_q;
    assign burst_active = burst_active_q;

endmodule

// File: tb/tb_ahb_rr_burst_arbiter.sv
// Scoreboard bench for ahb_rr_burst_arbiter: driver pushes reference-model expectations,
// monitor pops and compares one edge later.
module tb_ahb_rr_burst_arbiter;
    localparam int N  = 4;
    localparam int PW = 2;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic [N-1:0]  req_port = '0;
    logic          HREADYM = 1'b1;
    logic          HSELM = 1'b0;
    logic [1:0]    HTRANSM = 2'b00;
    logic [2:0]    HBURSTM = 3'b000;
    logic          HMASTLOCKM = 1'b0;
    logic [PW-1:0] addr_in_port;
    logic          no_port;
    logic          burst_active;

    ahb_rr_burst_arbiter #(.NUM_PORTS(N), .PORT_W(PW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(addr_in_port), .no_port(no_port), .burst_active(burst_active)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int addr;
        int nop;
        int bact;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int passed = 0;
    int cyc = 0;
    bit done = 0;

    // Reference model state
    int m_addr = 0, m_nop = 1, m_cnt = 0, m_last = N - 1;

    function automatic int burst_beats(input int b);
        if (b >= 6) return 16;
        if (b >= 4) return 8;
        if (b >= 2) return 4;
        return 1;
    endfunction

    task automatic model(input bit rst, rdy, sel, input int req, tr, bu, input bit lk);
        int ncnt;
        bit hold, found;
        int win;
        if (rst) begin
            m_addr = 0; m_nop = 1; m_cnt = 0; m_last = N - 1;
            return;
        end
        if (!rdy) return;
        ncnt = m_cnt;
        if (tr == 0) ncnt = 0;
        else if (tr == 2) ncnt = sel ? burst_beats(bu) - 1 : 0;
        else if (tr == 3 && sel) ncnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        hold = lk || (ncnt != 0) || (bu == 1 && sel && (tr == 1 || tr == 3));
        found = 0;
        win = 0;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int p = N - 1; p >= 0; p--)
            if ((req >> p) & 1) begin found = 1; win = p; end
`else
        for (int off = N; off >= 1; off--) begin
            int p;
            p = (m_last + off) % N;
            if ((req >> p) & 1) begin found = 1; win = p; end
        end
`endif
        if (hold) m_nop = 0;
        else if (found) begin m_addr = win; m_last = win; m_nop = 0; end
        else m_nop = sel ? 0 : 1;
        m_cnt = ncnt;
    endtask

    task automatic step(input bit rst, rdy, sel, input int req, tr, bu, input bit lk);
        exp_t e;
        @(negedge HCLK);
        HRESET = rst; HREADYM = rdy; HSELM = sel; req_port = N'(req);
        HTRANSM = 2'(tr); HBURSTM = 3'(bu); HMASTLOCKM = lk;
        model(rst, rdy, sel, req, tr, bu, lk);
        cyc++;
        e.addr = m_addr; e.nop = m_nop; e.bact = (m_cnt != 0) ? 1 : 0; e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string name, input int got, input int want, input int c);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, got, want);
    endtask

    // Monitor: every edge that follows a driven cycle has one expectation waiting.
    initial begin
        exp_t e;
        forever begin
            @(posedge HCLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("addr_in_port", int'(addr_in_port), e.addr, e.cyc);
                cmp("no_port", int'(no_port), e.nop, e.cyc);
                cmp("burst_active", int'(burst_active), e.bact, e.cyc);
                $display("cycle %0d: addr=%0d no_port=%0d burst_active=%0d", e.cyc,
                         addr_in_port, no_port, burst_active);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        // Round-robin with all requesting, SINGLE NONSEQ each cycle
        for (int i = 0; i < 6; i++) step(0, 1, 1, 4'b1111, 2, 0, 0);
        // INCR8 on port 1 with ports 0 and 2 requesting
        step(0, 1, 1, 4'b0101, 2, 3'b101, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 1, 4'b0101, 3, 3'b101, 0);
        // INCR with BUSY/SEQ continuation then IDLE, port 3 requesting
        step(0, 1, 1, 4'b1000, 2, 3'b001, 0);
        step(0, 1, 1, 4'b1000, 1, 3'b001, 0);
        step(0, 1, 1, 4'b1000, 3, 3'b001, 0);
        step(0, 1, 1, 4'b1000, 3, 3'b001, 0);
        step(0, 1, 1, 4'b1000, 0, 3'b001, 0);
        // Locked transfers then wait states
        for (int i = 0; i < 5; i++) step(0, 1, 1, 4'b1110, 2, 0, 1);
        step(0, 1, 1, 4'b0100, 2, 3'b011, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 4'b1011, 3, 0, 0);
        step(0, 1, 1, 4'b1011, 0, 0, 0);
        // WRAP4 interrupted by reset, then idle with no requests
        step(0, 1, 1, 4'b0001, 2, 3'b010, 0);
        step(0, 1, 1, 4'b0001, 3, 3'b010, 0);
        step(1, 0, 1, 4'b0001, 3, 3'b010, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 2, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit rst, rdy, sel, lk;
            int req, tr, bu;
            rst = ($urandom_range(0, 99) < 2);
            rdy = ($urandom_range(0, 99) < 80);
            sel = ($urandom_range(0, 99) < 80);
            lk  = ($urandom_range(0, 99) < 8);
            req = int'($urandom_range(0, 15));
            tr  = int'($urandom_range(0, 3));
            bu  = int'($urandom_range(0, 7));
            step(rst, rdy, sel, req, tr, bu, lk);
        end
        @(negedge HCLK);
        @(negedge HCLK);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
